// File: rtl/afpm_host_driver.sv
// Host-side driver for the byte-serial logarithmic FP16 multiplier.
// Serializes an operand pair low byte first onto ui_in/uio_in. After a fixed
// response latency it collects the two result bytes from uo_out. It also
// sequences the multiplier's rst_n and ena after the driver leaves reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RST_HOLD | multiplier held in reset for RST_CYC cycles
// IDLE     | s_ready high, waiting for an operand pair
// SEND_LO  | next edge drives A[7:0]/B[7:0] onto the pins
// SEND_HI  | next edge drives A[15:8]/B[15:8] onto the pins
// WAIT     | pins idle, response latency counted down
// CAP_LO   | uo_out captured into result[7:0] at end of cycle
// CAP_HI   | uo_out captured into result[15:8] at end of cycle
// DONE     | result presented, waiting for m_ready
module afpm_host_driver #(
  parameter int RESP_LAT = 3,
  parameter int RST_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_a,
  input  logic [15:0] s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_result,
  output logic [7:0]  dut_ui,
  output logic [7:0]  dut_uio,
  input  logic [7:0]  dut_uo,
  output logic        dut_ena,
  output logic        dut_rst_n,
  output logic [7:0]  txn_count
);

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SEND_LO,
    SEND_HI,
    WAIT,
    CAP_LO,
    CAP_HI,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RST_CYC - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(RESP_LAT - 1);

  state_t      r_state;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [7:0]  r_ui;
  logic [7:0]  r_uio;
  logic [15:0] r_result;
  logic        r_m_valid;
  logic        r_s_ready;
  logic        r_rst_n;
  logic        r_ena;
  logic [7:0]  r_txn_count;

  state_t      w_state_nxt;
  logic [7:0]  w_hold_cnt_nxt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [15:0] w_a_nxt;
  logic [15:0] w_b_nxt;
  logic [7:0]  w_ui_nxt;
  logic [7:0]  w_uio_nxt;
  logic [15:0] w_result_nxt;
  logic        w_m_valid_nxt;
  logic        w_s_ready_nxt;
  logic        w_rst_n_nxt;
  logic        w_ena_nxt;
  logic [7:0]  w_txn_count_nxt;

  // State and sequencing counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_HOLD;
      r_hold_cnt <= 8'd0;
      r_wait_cnt <= 8'd0;
      r_a        <= 16'd0;
      r_b        <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
    end
  end

  // Registered outputs; every port comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ui        <= 8'd0;
      r_uio       <= 8'd0;
      r_result    <= 16'd0;
      r_m_valid   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_rst_n     <= 1'b0;
      r_ena       <= 1'b0;
      r_txn_count <= 8'd0;
    end else begin
      r_ui        <= w_ui_nxt;
      r_uio       <= w_uio_nxt;
      r_result    <= w_result_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_rst_n     <= w_rst_n_nxt;
      r_ena       <= w_ena_nxt;
      r_txn_count <= w_txn_count_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_ui_nxt        = r_ui;
    w_uio_nxt       = r_uio;
    w_result_nxt    = r_result;
    w_m_valid_nxt   = r_m_valid;
    w_s_ready_nxt   = r_s_ready;
    w_rst_n_nxt     = r_rst_n;
    w_ena_nxt       = r_ena;
    w_txn_count_nxt = r_txn_count;

    unique case (r_state)
      RST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_hold_cnt_nxt = 8'd0;
          w_rst_n_nxt    = 1'b1;
          w_ena_nxt      = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      IDLE: begin
        w_ui_nxt  = 8'd0;
        w_uio_nxt = 8'd0;
        // s_ready comes up one cycle after entry from RST_HOLD, so the
        // multiplier sees at least one enabled idle cycle before data.
        if (s_valid && r_s_ready) begin
          w_a_nxt       = s_a;
          w_b_nxt       = s_b;
          w_s_ready_nxt = 1'b0;
          w_state_nxt   = SEND_LO;
        end else begin
          w_s_ready_nxt = 1'b1;
        end
      end
      SEND_LO: begin
        w_ui_nxt    = r_a[7:0];
        w_uio_nxt   = r_b[7:0];
        w_state_nxt = SEND_HI;
      end
      SEND_HI: begin
        w_ui_nxt       = r_a[15:8];
        w_uio_nxt      = r_b[15:8];
        w_wait_cnt_nxt = WAIT_LOAD;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        w_ui_nxt  = 8'd0;
        w_uio_nxt = 8'd0;
        if (r_wait_cnt == 8'd0) begin
          w_state_nxt = CAP_LO;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 8'd1;
        end
      end
      CAP_LO: begin
        w_result_nxt[7:0] = dut_uo;
        w_state_nxt       = CAP_HI;
      end
      CAP_HI: begin
        w_result_nxt[15:8] = dut_uo;
        w_m_valid_nxt      = 1'b1;
        w_state_nxt        = DONE;
      end
      DONE: begin
        // Going straight to s_ready=1 here lets the next accept land one
        // edge after the result handshake.
        if (r_m_valid && m_ready) begin
          w_m_valid_nxt   = 1'b0;
          w_s_ready_nxt   = 1'b1;
          w_txn_count_nxt = r_txn_count + 8'd1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = RST_HOLD;
      end
    endcase
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_result  = r_result;
  assign dut_ui    = r_ui;
  assign dut_uio   = r_uio;
  assign dut_ena   = r_ena;
  assign dut_rst_n = r_rst_n;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_afpm_host_driver.sv
// Bench for afpm_host_driver. A behavioural multiplier stand-in drives random
// junk on uo_out, except at the two capture cycles where it drives the chosen
// result bytes. The transaction count is tracked as a modulo-256 integer.
module tb_afpm_host_driver;

  localparam int RESP_LAT = 3;
  localparam int RST_CYC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_a = 16'd0;
  logic [15:0] s_b = 16'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_result;
  logic [7:0]  dut_ui;
  logic [7:0]  dut_uio;
  logic [7:0]  dut_uo = 8'd0;
  logic        dut_ena;
  logic        dut_rst_n;
  logic [7:0]  txn_count;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  afpm_host_driver #(
    .RESP_LAT(RESP_LAT),
    .RST_CYC (RST_CYC)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_result (m_result),
    .dut_ui   (dut_ui),
    .dut_uio  (dut_uio),
    .dut_uo   (dut_uo),
    .dut_ena  (dut_ena),
    .dut_rst_n(dut_rst_n),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rst_n"}, 32'(dut_rst_n), 32'd0);
    check_eq({tag, "_ena"}, 32'(dut_ena), 32'd0);
    check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_ui"}, 32'(dut_ui), 32'd0);
    check_eq({tag, "_uio"}, 32'(dut_uio), 32'd0);
    check_eq({tag, "_result"}, 32'(m_result), 32'd0);
    check_eq({tag, "_txn"}, 32'(txn_count), 32'd0);
  endtask

  // Assert rst asynchronously, hold it, release, and follow the bring-up.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (hold) step();
    check_all_zero("rst_held");
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 1; i <= RST_CYC; i++) begin
      step();
      check_eq("bringup_rst_n", 32'(dut_rst_n), 32'(i == RST_CYC));
      check_eq("bringup_ena", 32'(dut_ena), 32'(i == RST_CYC));
      check_eq("bringup_s_ready", 32'(s_ready), 32'd0);
    end
    step();
    check_eq("bringup_s_ready_late", 32'(s_ready), 32'd1);
    check_eq("bringup_rst_n_stays", 32'(dut_rst_n), 32'd1);
    check_eq("bringup_m_valid", 32'(m_valid), 32'd0);
    check_eq("bringup_ui", 32'(dut_ui), 32'd0);
    check_eq("bringup_txn", 32'(txn_count), 32'd0);
  endtask

  // One full operand/result exchange against the pin schedule.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input int gap, input int hold, output int acc_cyc);
    int budget;
    budget = 0;
    while (!s_ready && budget < 50) begin
      step();
      budget++;
    end
    check_eq("ready_wait", 32'(s_ready), 32'd1);
    repeat (gap) begin
      s_valid = 1'b0;
      step();
      check_eq("idle_s_ready", 32'(s_ready), 32'd1);
      check_eq("idle_ui", 32'(dut_ui), 32'd0);
    end
    m_ready = (hold == 0);
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    dut_uo = 8'($urandom);
    step();
    acc_cyc = cyc;
    s_valid = 1'b0;
    s_a = 16'($urandom);
    s_b = 16'($urandom);
    check_eq("accept_s_ready", 32'(s_ready), 32'd0);
    check_eq("accept_ui", 32'(dut_ui), 32'd0);
    check_eq("accept_uio", 32'(dut_uio), 32'd0);
    step();
    check_eq("lo_ui", 32'(dut_ui), 32'(a[7:0]));
    check_eq("lo_uio", 32'(dut_uio), 32'(b[7:0]));
    step();
    check_eq("hi_ui", 32'(dut_ui), 32'(a[15:8]));
    check_eq("hi_uio", 32'(dut_uio), 32'(b[15:8]));
    for (int i = 0; i < RESP_LAT; i++) begin
      s_valid = 1'($urandom);
      s_a = 16'($urandom);
      s_b = 16'($urandom);
      dut_uo = 8'($urandom);
      step();
      check_eq("wait_ui", 32'(dut_ui), 32'd0);
      check_eq("wait_uio", 32'(dut_uio), 32'd0);
      check_eq("wait_m_valid", 32'(m_valid), 32'd0);
      check_eq("wait_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    dut_uo = lo;
    step();
    check_eq("cap_lo_m_valid", 32'(m_valid), 32'd0);
    dut_uo = hi;
    step();
    dut_uo = 8'($urandom);
    check_eq("latency_m_valid", 32'(m_valid), 32'd1);
    check_eq("result", 32'(m_result), 32'({hi, lo}));
    check_eq("done_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("bp_m_valid", 32'(m_valid), 32'd1);
      check_eq("bp_result", 32'(m_result), 32'({hi, lo}));
      check_eq("bp_s_ready", 32'(s_ready), 32'd0);
      check_eq("bp_ui", 32'(dut_ui), 32'd0);
    end
    m_ready = 1'b1;
    step();
    exp_cnt = (exp_cnt + 1) % 256;
    check_eq("hs_m_valid", 32'(m_valid), 32'd0);
    check_eq("hs_s_ready", 32'(s_ready), 32'd1);
    check_eq("hs_txn_count", 32'(txn_count), 32'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int t2;
    @(posedge clk);
    #1;
    do_reset(3);

    do_txn(16'h3E00, 16'h4200, 8'h80, 8'h44, 0, 0, t0);
    check_eq("single_txn_count", 32'(txn_count), 32'd1);

    do_txn(16'($urandom), 16'($urandom), 8'h5A, 8'hC3, 1, 10, t0);

    do_txn(16'h0101, 16'h0101, 8'h02, 8'h01, 0, 0, t1);
    do_txn(16'h3C00, 16'hBC00, 8'h00, 8'hBC, 0, 0, t2);
    check_eq("b2b_spacing", 32'(t2 - t1), 32'(RESP_LAT + 6));

    s_a = 16'h1234;
    s_b = 16'h5678;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (3) step();
    check_eq("midop_m_valid", 32'(m_valid), 32'd0);
    check_eq("midop_rst_n_before", 32'(dut_rst_n), 32'd1);
    do_reset(2);
    do_txn(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 0, 0, t0);
    check_eq("midop_recover_txn", 32'(txn_count), 32'd1);

    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      do_txn(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), t0);
      if (i == 254) check_eq("wrap_255", 32'(txn_count), 32'd255);
    end
    check_eq("wrap_zero", 32'(txn_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
